duty_pwm_gen: RTL

- Synthesizable, multi-channel successor to the real-valued duty-to-clock primitive.
- Turns a per-channel digital duty code into a fixed-period clock/PWM waveform.
- One shared period counter; per-channel active and shadow duty registers; glitch-free updates only at period boundaries.
- Feeds the digital neuron spike/clock paths in place of behavioural duty sources.

---
 rtl/duty_pwm_pkg.sv | 24 ++
 rtl/duty_pwm_chan.sv | 67 ++++++
 rtl/duty_pwm_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/duty_pwm_pkg.sv
// ----------------------------------------------------------------------------
// duty_pwm_pkg : shared width helper, duty clamp and duty-code type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package duty_pwm_pkg;

    localparam int DUTY_MAX_W = 16;

    // Wide container so the clamp works for any configured code width.
    typedef logic [DUTY_MAX_W-1:0] duty_code_t;

    function automatic int dw_f(input int period);
        return $clog2(period + 1);
    endfunction

    function automatic duty_code_t sat_duty(input duty_code_t duty, input duty_code_t period);
        return (duty > period) ? period : duty;
    endfunction

endpackage

`default_nettype wire

// File: rtl/duty_pwm_chan.sv
// ----------------------------------------------------------------------------
// duty_pwm_chan : one PWM channel with shadow/active duty and registered output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module duty_pwm_chan
    import duty_pwm_pkg::*;
#(
    parameter int PERIOD    = 16,
    parameter int DW        = 5,
    parameter int DUTY_INIT = 8,
    parameter int PHASE     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wrap,
    input  logic          wr,
    input  logic [DW-1:0] duty,
    input  logic [DW-1:0] cnt,
    output logic          pending,
    output logic          out
);

    logic [DW-1:0] shadow;
    logic [DW-1:0] active;
    logic [DW:0]   phase_sum;
    logic [DW-1:0] phase_cnt;
    logic [DW-1:0] duty_sat;

    assign duty_sat = DW'(sat_duty(duty_code_t'(duty), duty_code_t'(PERIOD)));

    always_comb begin
        phase_sum = {1'b0, cnt} + (DW+1)'(PHASE);
        phase_cnt = phase_sum[DW-1:0];
        if (phase_sum >= (DW+1)'(PERIOD)) begin
            phase_cnt = DW'(phase_sum - (DW+1)'(PERIOD));
        end
    end

    // A write landing on the boundary bypasses the shadow and goes live directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            active  <= DW'(DUTY_INIT);
            pending <= 1'b0;
            out     <= 1'b0;
        end else begin
            if (wrap) begin
                pending <= 1'b0;
                if (wr) begin
                    active <= duty_sat;
                end else if (pending) begin
                    active <= shadow;
                end
            end else if (wr) begin
                shadow  <= duty_sat;
                pending <= 1'b1;
            end
            out <= en && (phase_cnt < active);
        end
    end

endmodule

`default_nettype wire

// File: rtl/duty_pwm_gen.sv
// ----------------------------------------------------------------------------
// duty_pwm_gen : multi-channel duty-code to PWM/clock generator, shared counter
// Optional: DUTY_PWM_PHASE_STAGGER_EN staggers channel phases across the period
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module duty_pwm_gen
    import duty_pwm_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int PERIOD    = 16,
    parameter int DW        = dw_f(PERIOD),
    parameter int DUTY_INIT = PERIOD / 2,
    localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CHW-1:0]  in_ch,
    input  logic [DW-1:0]   in_duty,
    output logic [N_CH-1:0] out,
    output logic            period_start
);

    logic [DW-1:0]   cnt;
    logic            wrap;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] wr;

    // Disabled cycles count as boundaries so writes made while idle go live.
    assign wrap = !en || (cnt == DW'(PERIOD - 1));

    always_comb begin
        in_ready = 1'b1;
        wr       = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_ch == CHW'(i)) begin
                in_ready = !pending[i];
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            wr[i] = in_valid && in_ready && (in_ch == CHW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= en && (cnt == '0);
            if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
`ifdef DUTY_PWM_PHASE_STAGGER_EN
        localparam int CH_PHASE = (i * PERIOD / N_CH) % PERIOD;
`else
        localparam int CH_PHASE = 0;
`endif
        duty_pwm_chan #(
            .PERIOD    (PERIOD),
            .DW        (DW),
            .DUTY_INIT (DUTY_INIT),
            .PHASE     (CH_PHASE)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wrap    (wrap),
            .wr      (wr[i]),
            .duty    (in_duty),
            .cnt     (cnt),
            .pending (pending[i]),
            .out     (out[i])
        );
    end

endmodule

`default_nettype wire
